apbspi_shift_engine: RTL
========================

Name: apbspi_shift_engine

Overview:
SPI master transfer engine that consumes the SCK half-period timebase from the prescaler stage, presented as a one-cycle half_tick strobe in the clk domain. It serialises one DATA_W-bit word per transaction on MOSI, captures MISO, and drives SCK and CS_N for all four CPOL/CPHA modes. Upstream, the APB register block hands over words through a valid/ready handshake. Downstream, the register block receives each captured word as a one-cycle result pulse.

Parameters:
DATA_W, 8, word length in bits (legal range 4..32).
CNT_W, $clog2(2*DATA_W+1), width of the SCK edge counter.

Ports:
clk  input  1  system clock
nrst  input  1  reset, asynchronous, active-low
half_tick  input  1  one-clk strobe per SCK half period; ignored in IDLE
cpol  input  1  SCK idle level; tracked in IDLE, latched at accept
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accept
lsb_first  input  1  bit order; latched at accept
tx_valid  input  1  word available
tx_ready  output  1  engine can accept a word (high only in IDLE)
tx_data  input  DATA_W  word to transmit
rx_valid  output  1  one-clk pulse when a transfer completes
rx_data  output  DATA_W  captured word; holds until the next completion
busy  output  1  high in any state other than IDLE
sck  output  1  serial clock, registered
mosi  output  1  serial data out, registered
miso  input  1  serial data in, already synchronised upstream
cs_n  output  1  chip select, active-low, registered

Behaviour:
- Reset values: sck=0, mosi=0, cs_n=1, busy=0, rx_valid=0, rx_data=0, state=IDLE, counters=0.
- States: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE. All registered.
- IDLE
  - tx_ready=1; sck <= cpol every cycle.
  - Accept occurs on tx_valid & tx_ready. On accept: latch tx_data into the shift register, latch cpol/cpha/lsb_first, cs_n <= 0, go to LEAD.
  - If cpha=0, mosi <= first bit on the accept cycle (MSB, or LSB when lsb_first).
- LEAD: wait for the next half_tick (CS setup = one half period), then go to SHIFT with edge counter = 0.
- SHIFT
  - Each half_tick: sck toggles and the edge counter increments.
  - Odd edges (1, 3, ...) are leading; even edges are trailing.
  - cpha=0: sample miso on leading edges; shift out the next bit on trailing edges, except the final trailing edge.
  - cpha=1: drive the next bit on leading edges; sample on trailing edges.
  - After edge 2*DATA_W, sck is back at the latched cpol; go to TRAIL.
- TRAIL: on the next half_tick (CS hold), cs_n <= 1 and go to IDLE.
  - In that same cycle: rx_valid=1, rx_data <= the assembled word, ordered per latched lsb_first so rx_data[DATA_W-1] is always the word MSB.
- Timing
  - The engine acts only on cycles where half_tick=1; any number of idle clk cycles between ticks is legal.
  - Back-to-back half_tick on every clk is legal (fastest mode).
  - A transfer takes exactly 2*DATA_W+2 half_ticks from LEAD entry to the return to IDLE.
  - A new word can be accepted the cycle after the return to IDLE, so CS_N deasserts for at least one clk.
- Boundary conditions
  - tx_valid held high while busy: not accepted, no side effects.
  - cpol/cpha/lsb_first change mid-transfer: ignored until the next accept.
  - half_tick coincident with accept: the tick is ignored (state was IDLE).
  - nrst asserted mid-transfer: all outputs go to reset values immediately; no rx_valid; the partial word is discarded.

Decomposition:
- Package apbspi_pkg holds:
  - typedef enum logic [1:0] spi_state_t {IDLE, LEAD, SHIFT, TRAIL};
  - localparam SPI_DATA_W_DEFAULT = 8.
- One natural sub-module: apbspi_shreg. It is a DATA_W bidirectional shift register with load, shift_out and sample_in controls and lsb_first direction select, exposing a current-out bit and the assembled word.
- FSM, edge counter and SCK/CS_N generation stay in the top.

Test Plan:
1. Mode 0, MSB first, DATA_W=8, tx_data=0xA5, miso looped to mosi, half_tick every 3rd clk -> mosi bits 1,0,1,0,0,1,0,1 valid on leading edges; exactly 8 rising SCK edges; rx_data=0xA5; rx_valid pulses once; 18 half_ticks total.
2. Mode 3 (cpol=1, cpha=1), lsb_first=1, tx_data=0x3C, miso driven from a slave model returning 0x81 LSB-first -> sck idles high; first mosi bit is 0; rx_data=0x81; cs_n low for the whole transfer.
3. Modes 1 and 2, half_tick every clk, two back-to-back words 0x00 and 0xFF -> the second word is accepted the clk after the first returns to IDLE; cs_n high for exactly 1 clk between words; both rx_data values correct.
4. tx_valid held high and cpol toggled during SHIFT -> no second accept until IDLE; sck waveform unchanged; tx_ready=0 throughout busy.
5. nrst pulsed after the 5th SHIFT edge -> sck=0, cs_n=1, busy=0, rx_valid never asserted; a following 0x5A transfer completes normally.
6. DATA_W=32, tx_data=0xDEADBEEF, loopback, half_tick period 7 clk -> rx_data=0xDEADBEEF; exactly 66 half_ticks counted from LEAD entry to IDLE.

Source files
------------

// File: rtl/apbspi_shift_engine_pkg.sv
// apbspi_pkg
//   Shared types and defaults for the APB SPI shift engine slice.
//   - spi_state_t        : transfer engine state encoding
//   - SPI_DATA_W_DEFAULT : default serial word length in bits
package apbspi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  localparam int SPI_DATA_W_DEFAULT = 8;

endpackage

// File: rtl/apbspi_shift_engine_shreg.sv
// apbspi_shreg
//   Bidirectional serial shift register for one SPI word.
//   Ports:
//     clk, nrst   : clock, asynchronous active-low reset
//     load        : capture load_data as the word to transmit, clear capture
//     load_data   : parallel word to transmit
//     shift_out   : advance the transmit word by one bit
//     sample_in   : shift sin into the receive word
//     lsb_first   : bit order (0 = MSB first, 1 = LSB first)
//     sin         : serial input bit
//     cur_bit     : bit currently at the transmit head
//     nxt_bit     : bit that becomes the head after the next shift_out
//     word        : assembled receive word, word[DATA_W-1] is the word MSB
module apbspi_shreg
  import apbspi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_out,
  input  logic              sample_in,
  input  logic              lsb_first,
  input  logic              sin,
  output logic              cur_bit,
  output logic              nxt_bit,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;

  // Transmit and receive halves are kept separate because, with cpha=0,
  // sampling and shifting happen on different SCK edges of the same bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load) begin
        tx_q <= load_data;
      end else if (shift_out) begin
        tx_q <= lsb_first ? (tx_q >> 1) : (tx_q << 1);
      end

      if (load) begin
        rx_q <= '0;
      end else if (sample_in) begin
        // Inserting at the far end for LSB-first means the first sampled
        // bit ends up at bit 0 after DATA_W samples, so word stays MSB-aligned.
        rx_q <= lsb_first ? {sin, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], sin};
      end
    end
  end

  assign cur_bit = lsb_first ? tx_q[0] : tx_q[DATA_W-1];
  assign nxt_bit = lsb_first ? tx_q[1] : tx_q[DATA_W-2];
  assign word    = rx_q;

endmodule

// File: rtl/apbspi_shift_engine.sv
// apbspi_shift_engine
//   SPI master transfer engine. Serialises one DATA_W-bit word per
//   transaction on mosi, captures miso, and generates sck / cs_n for all
//   four CPOL/CPHA modes. All timing advances on half_tick strobes from the
//   prescaler; a transfer is 2*DATA_W+2 half_ticks from LEAD to IDLE.
//   Ports:
//     clk, nrst            : clock, asynchronous active-low reset
//     half_tick            : one-clk strobe per SCK half period (ignored in IDLE)
//     cpol, cpha, lsb_first: mode controls, latched when a word is accepted
//     tx_valid/tx_ready    : word handover from the register block
//     tx_data              : word to transmit
//     rx_valid             : one-clk pulse when a transfer completes
//     rx_data              : captured word, MSB at rx_data[DATA_W-1]
//     busy                 : engine is not IDLE
//     sck, mosi, cs_n      : registered SPI outputs
//     miso                 : serial input, already synchronised
module apbspi_shift_engine
  import apbspi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT,
  parameter int CNT_W  = $clog2(2*DATA_W+1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              half_tick,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2*DATA_W);

  spi_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, edge_nxt;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              cpol_q, cpha_q, lsb_q;

  logic              accept;
  logic              shift_out;
  logic              sample_in;
  logic              cur_bit;
  logic              nxt_bit;
  logic [DATA_W-1:0] rx_word;

  apbspi_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk       (clk),
    .nrst      (nrst),
    .load      (accept),
    .load_data (tx_data),
    .shift_out (shift_out),
    .sample_in (sample_in),
    .lsb_first (lsb_q),
    .sin       (miso),
    .cur_bit   (cur_bit),
    .nxt_bit   (nxt_bit),
    .word      (rx_word)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    accept     = 1'b0;
    shift_out  = 1'b0;
    sample_in  = 1'b0;
    edge_nxt   = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        // sck follows the live cpol so the line already sits at the right
        // idle level when the next word arrives; half_tick is ignored here.
        sck_d = cpol;
        cnt_d = '0;
        if (tx_valid) begin
          accept  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = LEAD;
          // cpha=0 needs the first bit on the wire before the first edge.
          if (!cpha) begin
            mosi_d = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
          end
        end
      end

      LEAD: begin
        // One half period of CS setup before the first SCK edge.
        if (half_tick) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end

      SHIFT: begin
        if (half_tick) begin
          sck_d = ~sck_q;
          cnt_d = edge_nxt;
          // Odd edge numbers are leading edges, even ones trailing.
          if (edge_nxt[0]) begin
            if (!cpha_q) begin
              sample_in = 1'b1;
            end else begin
              mosi_d    = cur_bit;
              shift_out = 1'b1;
            end
          end else begin
            if (cpha_q) begin
              sample_in = 1'b1;
            end else if (edge_nxt != LAST_EDGE) begin
              mosi_d    = nxt_bit;
              shift_out = 1'b1;
            end
          end
          if (edge_nxt == LAST_EDGE) begin
            state_d = TRAIL;
          end
        end
      end

      TRAIL: begin
        // One half period of CS hold, then hand the word upstream.
        if (half_tick) begin
          sck_d      = cpol_q;
          cs_n_d     = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_word;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q      <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      if (accept) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q  <= lsb_first;
      end
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule
